cpu8_program_sequencer: RTL and testbench

- Upstream feeder for the 8-bit accumulator core: stores a short program and issues one instruction byte per enabled cycle.
- Each instruction byte is {operand[7:4], opcode[3:0]} and drives the core's ui_in bus directly.
- The program is loaded byte-serially over the bidirectional inputs.
- The sequencer executes its own control opcodes (JMP, JZ, HALT) locally and sends NOP in their place.

---
 rtl/cpu8_pkg.sv | 33 +++
 rtl/cpu8_prog_mem.sv | 29 ++
 rtl/cpu8_program_sequencer.sv | 142 ++++++++++++++
 tb/tb_cpu8_program_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit accumulator core and its program sequencer:
// opcode map, program-memory geometry and sequencer state encoding.
package cpu8_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [7:0] INSTR_NOP = 8'h00;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    WAIT_Z = 3'd3,
    HALT   = 3'd4
  } seq_state_t;

  // Control opcodes are consumed by the sequencer and never reach the core.
  function automatic logic is_local_op(input logic [3:0] op);
    return (op == OP_JZ) || (op == OP_JMP) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/cpu8_prog_mem.sv
// 16x8 program store: one synchronous write port, one combinational read port,
// cleared to NOP by the asynchronous reset.
module cpu8_prog_mem
  import cpu8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= INSTR_NOP;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu8_program_sequencer.sv
// Program sequencer feeding the accumulator core: byte-serial program load,
// one instruction per enabled cycle, local handling of JZ / JMP / HALT.
module cpu8_program_sequencer
  import cpu8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  output logic [ADDR_W:0]   load_count,
  input  logic              run,
  input  logic              acc_zero,
  output logic [7:0]        instr_out,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] PC_ONE  = 1;
  localparam logic [ADDR_W:0]   PTR_ONE = 1;
  localparam logic [1:0]        JZ_WAIT = 2'd2;

  seq_state_t        state, state_next;
  logic [ADDR_W:0]   wr_ptr, wr_ptr_next;
  logic [ADDR_W-1:0] pc_next;
  logic [7:0]        instr_next;
  logic [1:0]        wait_cnt, wait_next;
  logic              mem_we;
  logic [7:0]        fetch;
  logic [3:0]        fetch_op;
  logic [ADDR_W-1:0] fetch_tgt;
  logic              ptr_full;

  cpu8_prog_mem u_prog_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (load_data),
    .raddr (pc),
    .rdata (fetch)
  );

  assign fetch_op   = fetch[3:0];
  assign fetch_tgt  = fetch[7:4];
  assign ptr_full   = wr_ptr[ADDR_W];
  assign load_count = wr_ptr;

  // All sequencer state advances only on enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      pc        <= '0;
      instr_out <= INSTR_NOP;
      wait_cnt  <= '0;
    end else if (ena) begin
      state     <= state_next;
      wr_ptr    <= wr_ptr_next;
      pc        <= pc_next;
      instr_out <= instr_next;
      wait_cnt  <= wait_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load_en)  state_next = LOAD;
        else if (run) state_next = RUN;
      end
      LOAD: begin
        if (!load_en) state_next = IDLE;
      end
      RUN: begin
        if (!run)                       state_next = IDLE;
        else if (fetch_op == OP_JZ)     state_next = WAIT_Z;
        else if (fetch_op == OP_HALT)   state_next = HALT;
      end
      WAIT_Z: begin
        if (!run)               state_next = IDLE;
        else if (wait_cnt == 2'd1) state_next = RUN;
      end
      HALT: begin
        if (!run) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath updates; every non-issuing cycle drives NOP to the core.
  always_comb begin
    pc_next     = pc;
    instr_next  = INSTR_NOP;
    wr_ptr_next = wr_ptr;
    wait_next   = wait_cnt;
    mem_we      = 1'b0;
    load_ready  = (state == LOAD) && !ptr_full;
    halted      = (state == HALT);
    busy        = (state == RUN) || (state == WAIT_Z);
    case (state)
      IDLE: begin
        if (load_en)  wr_ptr_next = '0;
        else if (run) pc_next     = '0;
      end
      LOAD: begin
        if (load_valid && !ptr_full) begin
          mem_we      = ena;
          wr_ptr_next = wr_ptr + PTR_ONE;
        end
      end
      RUN: begin
        if (run) begin
          if (!is_local_op(fetch_op)) begin
            instr_next = fetch;
            pc_next    = pc + PC_ONE;
          end else if (fetch_op == OP_JMP) begin
            pc_next = fetch_tgt;
          end else if (fetch_op == OP_JZ) begin
            wait_next = JZ_WAIT;
          end
        end
      end
      WAIT_Z: begin
        // The JZ byte is still at mem[pc], so its target is re-read here.
        if (run) begin
          if (wait_cnt == 2'd1) pc_next = acc_zero ? fetch_tgt : (pc + PC_ONE);
          else                  wait_next = wait_cnt - 2'd1;
        end
      end
      HALT: begin
        if (!run) pc_next = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu8_program_sequencer.sv
// Directed self-checking bench for cpu8_program_sequencer.
module tb_cpu8_program_sequencer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       load_en;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic [4:0] load_count;
  logic       run;
  logic       acc_zero;
  logic [7:0] instr_out;
  logic [3:0] pc;
  logic       halted;
  logic       busy;

  int vectors;
  int miscompares;
  logic [7:0] prog [16];

  cpu8_program_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .load_en    (load_en),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_count (load_count),
    .run        (run),
    .acc_zero   (acc_zero),
    .instr_out  (instr_out),
    .pc         (pc),
    .halted     (halted),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic le, input logic lv,
                               input logic [7:0] ld, input logic r, input logic az);
    ena        = e;
    load_en    = le;
    load_valid = lv;
    load_data  = ld;
    run        = r;
    acc_zero   = az;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %02h expected %02h", tag, observed, expected);
    end
  endtask

  task automatic checkRun(input string tag, input logic [7:0] exp_instr, input logic [3:0] exp_pc);
    checkOutput({tag, ".instr"}, instr_out, exp_instr);
    checkOutput({tag, ".pc"}, 8'(pc), 8'(exp_pc));
  endtask

  // Loads prog[0..n-1] from IDLE and returns to IDLE.
  task automatic loadProgram(input int n);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, acc_zero);
    tick();
    checkOutput("load.ready_on_entry", 8'(load_ready), 8'h01);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, prog[i], 1'b0, acc_zero);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, acc_zero);
    tick();
    checkOutput("load.count", 8'(load_count), 8'(n));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("reset.instr", instr_out, 8'h00);
    checkOutput("reset.pc", 8'(pc), 8'h00);
    checkOutput("reset.load_count", 8'(load_count), 8'h00);
    checkOutput("reset.load_ready", 8'(load_ready), 8'h00);
    checkOutput("reset.halted", 8'(halted), 8'h00);
    checkOutput("reset.busy", 8'(busy), 8'h00);
    rst_n = 1'b1;
    tick();

    $display("[TB] straight-line program ending in HALT");
    prog[0] = 8'h31; prog[1] = 8'h21; prog[2] = 8'h0F;
    loadProgram(3);
    run = 1'b1;
    tick(); checkRun("t1.enter", 8'h00, 4'd0);
    checkOutput("t1.busy", 8'(busy), 8'h01);
    tick(); checkRun("t1.b0", 8'h31, 4'd1);
    tick(); checkRun("t1.b1", 8'h21, 4'd2);
    tick(); checkRun("t1.halt", 8'h00, 4'd2);
    checkOutput("t1.halted", 8'(halted), 8'h01);
    checkOutput("t1.busy_halt", 8'(busy), 8'h00);
    tick(); checkRun("t1.halt_hold", 8'h00, 4'd2);
    run = 1'b0;
    tick(); checkRun("t1.idle", 8'h00, 4'd0);
    checkOutput("t1.halted_clr", 8'(halted), 8'h00);

    $display("[TB] JMP loop");
    prog[0] = 8'h11; prog[1] = 8'h0E;
    loadProgram(2);
    run = 1'b1;
    tick(); checkRun("t2.enter", 8'h00, 4'd0);
    for (int k = 0; k < 3; k++) begin
      tick(); checkRun("t2.add", 8'h11, 4'd1);
      tick(); checkRun("t2.jmp", 8'h00, 4'd0);
    end
    run = 1'b0;
    tick();

    $display("[TB] JZ taken and not taken");
    prog[0] = 8'h3D; prog[1] = 8'h0F; prog[2] = 8'h00; prog[3] = 8'h0F;
    acc_zero = 1'b1;
    loadProgram(4);
    run = 1'b1;
    tick(); checkRun("t3.enter", 8'h00, 4'd0);
    tick(); checkRun("t3.jz", 8'h00, 4'd0);
    checkOutput("t3.busy_wait", 8'(busy), 8'h01);
    tick(); checkRun("t3.wait1", 8'h00, 4'd0);
    tick(); checkRun("t3.taken", 8'h00, 4'd3);
    tick(); checkRun("t3.halt", 8'h00, 4'd3);
    checkOutput("t3.halted", 8'(halted), 8'h01);
    run = 1'b0;
    tick(); checkRun("t3.idle", 8'h00, 4'd0);
    run = 1'b1;
    tick(); tick(); tick();
    acc_zero = 1'b0;
    tick(); checkRun("t3.not_taken", 8'h00, 4'd1);
    tick(); checkRun("t3.halt1", 8'h00, 4'd1);
    checkOutput("t3.halted1", 8'(halted), 8'h01);
    run = 1'b0;
    tick();

    $display("[TB] overlong load stream");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("t4.count_entry", 8'(load_count), 8'h00);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 8'(i + 1), 1'b0, 1'b0);
      tick();
      if (i == 14) begin
        checkOutput("t4.ready15", 8'(load_ready), 8'h01);
        checkOutput("t4.count15", 8'(load_count), 8'd15);
      end
      if (i >= 15) begin
        checkOutput("t4.ready_full", 8'(load_ready), 8'h00);
        checkOutput("t4.count_full", 8'(load_count), 8'd16);
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("t4.count_idle", 8'(load_count), 8'd16);
    run = 1'b1;
    tick(); checkRun("t4.enter", 8'h00, 4'd0);
    for (int i = 0; i < 12; i++) begin
      tick(); checkRun("t4.stream", 8'(i + 1), 4'(i + 1));
    end
    tick(); checkRun("t4.jz", 8'h00, 4'd12);
    tick(); tick(); checkRun("t4.jz_fall", 8'h00, 4'd13);
    tick(); checkRun("t4.jmp0", 8'h00, 4'd0);
    tick(); checkRun("t4.restart", 8'h01, 4'd1);
    run = 1'b0;
    tick();

    $display("[TB] pc wrap");
    for (int i = 0; i < 16; i++) prog[i] = {4'(i), 4'h1};
    loadProgram(16);
    run = 1'b1;
    tick(); checkRun("t5.enter", 8'h00, 4'd0);
    for (int i = 0; i < 16; i++) begin
      tick(); checkRun("t5.seq", {4'(i), 4'h1}, 4'(i + 1));
    end
    tick(); checkRun("t5.wrapped", 8'h01, 4'd1);

    $display("[TB] reset mid-run");
    tick();
    rst_n = 1'b0;
    #2;
    checkRun("t6.async", 8'h00, 4'd0);
    checkOutput("t6.busy", 8'(busy), 8'h00);
    tick();
    rst_n = 1'b1;
    checkOutput("t6.count", 8'(load_count), 8'h00);
    tick(); checkRun("t6.enter", 8'h00, 4'd0);
    tick(); tick(); tick(); checkRun("t6.cleared", 8'h00, 4'd3);
    run = 1'b0;
    tick();

    $display("[TB] enable freeze in RUN and WAIT_Z");
    prog[0] = 8'h21; prog[1] = 8'h31; prog[2] = 8'h5D; prog[3] = 8'h41;
    prog[4] = 8'h0F; prog[5] = 8'h51; prog[6] = 8'h0F;
    acc_zero = 1'b0;
    loadProgram(7);
    run = 1'b1;
    tick(); checkRun("t7.enter", 8'h00, 4'd0);
    tick(); checkRun("t7.b0", 8'h21, 4'd1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'(k), 1'b1, 8'hA5, 1'(k + 1), 1'(k));
      tick(); checkRun("t7.freeze_run", 8'h21, 4'd1);
      checkOutput("t7.freeze_busy", 8'(busy), 8'h01);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick(); checkRun("t7.resume", 8'h31, 4'd2);
    tick(); checkRun("t7.jz", 8'h00, 4'd2);
    tick(); checkRun("t7.wait", 8'h00, 4'd2);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'(k + 1), 1'b0, 8'h00, 1'(k), 1'(k + 1));
      tick(); checkRun("t7.freeze_wait", 8'h00, 4'd2);
      checkOutput("t7.freeze_wbusy", 8'(busy), 8'h01);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick(); checkRun("t7.taken", 8'h00, 4'd5);
    tick(); checkRun("t7.b5", 8'h51, 4'd6);
    tick(); checkRun("t7.halt", 8'h00, 4'd6);
    checkOutput("t7.halted", 8'(halted), 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
